// File: rtl/key_debounce16.sv
// Sixteen-key synchroniser/debouncer feeding the priority encoder; IN_N is active-low.
// Optional sticky display mode is enabled by defining KEY_HOLD_EN.
module key_debounce16 #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] KEY_N,
  output logic [15:0] IN_N,
  output logic        PRESS_P,
  output logic        ANY_N
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS);
  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);

  logic [15:0]         s1, s2;
  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [15:0]         deb, deb_nxt, deb_prev;
  logic [15:0][CW-1:0] cnt, cnt_nxt;
  logic [15:0]         press_vec;
  logic                any_src;
  logic                press_q, any_q;

  assign tick      = (pre_cnt == TICK_LAST);
  assign press_vec = deb_prev & ~deb;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1      <= '1;
      s2      <= '1;
      pre_cnt <= '0;
    end else begin
      s1      <= KEY_N;
      s2      <= s1;
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end
  end

  // A mismatch must persist across STABLE_TICKS ticks; any agreement clears progress.
  always_comb begin
    deb_nxt = deb;
    cnt_nxt = cnt;
    for (int i = 0; i < 16; i++) begin
      if (s2[i] == deb[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick && (cnt[i] == STABLE_LAST)) begin
        deb_nxt[i] = s2[i];
        cnt_nxt[i] = '0;
      end else if (tick) begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      deb      <= '1;
      deb_prev <= '1;
      cnt      <= '0;
    end else begin
      deb      <= deb_nxt;
      deb_prev <= deb;
      cnt      <= cnt_nxt;
    end
  end

`ifdef KEY_HOLD_EN
  logic [15:0] hold, hold_nxt;

  always_comb begin
    hold_nxt = hold;
    if (press_vec != '0) hold_nxt = ~press_vec;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) hold <= '1;
    else        hold <= hold_nxt;
  end

  assign IN_N    = hold;
  assign any_src = &hold_nxt;
`else
  assign IN_N    = deb;
  assign any_src = &deb_nxt;
`endif

  // ANY_N is registered from the next-state value so it moves with IN_N.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      press_q <= 1'b0;
      any_q   <= 1'b1;
    end else begin
      press_q <= |press_vec;
      any_q   <= any_src;
    end
  end

  assign PRESS_P = press_q;
  assign ANY_N   = any_q;

endmodule
